top_ps2_pcm: RTL and testbench
==============================

TOP_PS2_PCM -- requirements
Module: top_ps2_pcm

Interface
REQ-001 SHALL have parameter SYS_CLK_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter SAMPLE_HZ, default 32_000, PCM sample rate; sample strobe every SYS_CLK_HZ/SAMPLE_HZ cycles.
REQ-003 SHALL have parameter PLAY_SAMPLES, default 8000, tone length in samples (250 ms).
REQ-004 SHALL have parameter REFRESH_BITS, default 17, width of the display scan counter.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports ps2_clk and ps2_dat, input, 1 each, open-collector PS/2 lines, externally pulled up, asynchronous to clk.
REQ-008 SHALL have port aud, output, 1, registered delta-sigma audio bit.
REQ-009 SHALL have ports a,b,c,d,e,f,g and dp, output, 1 each, active-low segments.
REQ-010 SHALL have ports an0..an3, output, 1 each, active-low digit enables; an0 is the rightmost digit.

Function
REQ-011 SHALL synchronise ps2_clk/ps2_dat through 2 flops; a ps2_clk falling edge is accepted only after the line has held its new level for 8 consecutive clk cycles.
REQ-012 SHALL sample ps2_dat on each accepted falling edge into an 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-013 SHALL discard a frame with start=1, stop=0 or even parity (data+parity); the bit counter returns to 0.
REQ-014 SHALL push each valid byte into an 8-entry byte FIFO; a push while full is dropped; push and pop in the same cycle are both performed.
REQ-015 SHALL pop one FIFO byte per cycle whenever the FIFO is non-empty and feed it to the decoder.
REQ-016 Decoder: byte F0 sets a break flag; byte E0 is ignored; any other byte with the break flag set clears the flag and has no further effect; any other byte without the flag is a make code.
REQ-017 On a make code: latch the code into last_code, increment an 8-bit key_count (wraps 255->0), and (re)start playback with sample counter 0 and phase 0. A make code during playback restarts it.
REQ-018 Playback: 16-bit phase accumulator advances by {2'b00, last_code, 6'b000000} per sample strobe; phase[15:11] indexes a 32-entry 8-bit unsigned sine ROM (midscale 0x80).
REQ-019 Playback SHALL end after PLAY_SAMPLES sample strobes; the player then goes idle.
REQ-020 DAC: 9-bit accumulator, acc <= {1'b0, acc[7:0]} + sample on every clk cycle while playing; aud <= acc[8].
REQ-021 While idle, the DAC accumulator SHALL be held at 0 and aud at 0 (no toggling without a keypress).
REQ-022 Display: free-running REFRESH_BITS counter; its top 2 bits select digit 0..3, exactly one anode low at a time.
REQ-023 Digit 0 = last_code[3:0], digit 1 = last_code[7:4], digit 2 = key_count[3:0], digit 3 = FIFO occupancy (0-8), all in hex 0-F with standard 7-segment patterns.
REQ-024 dp SHALL be low only while digit 0 is selected and playback is active; otherwise high.

Reset
REQ-025 On rst: frame logic, break flag, FIFO (empty), last_code=0x00, key_count=0, player idle, phase=0, DAC acc=0, aud=0, scan counter=0.
REQ-026 First cycle after reset SHALL show an0=0, an1..an3=1, segments for "0", dp=1.
REQ-027 A reset in mid-frame or mid-playback SHALL abandon the frame and silence aud on the next edge.

Configuration
REQ-028 With macro PS2_TIMEOUT_EN defined, a partial frame with no accepted falling edge for SYS_CLK_HZ/1000 cycles (1 ms) SHALL be discarded and the bit counter cleared; without it, partial frames persist until completed or reset.

Verification
REQ-029 Send 0x1C (6 us clock periods, valid parity) -> within 500 us aud shows >100 rising edges; digits read 1,C; key_count=1; dp low on digit 0.
REQ-030 Send 0x1C with bad parity, then with bad start, then with bad stop -> aud stays 0, last_code stays 0x00, key_count 0.
REQ-031 Send F0 then 0x1C after idle -> no playback, key_count unchanged; then 0x1C -> playback starts.
REQ-032 Hold clk running with no PS/2 activity after reset -> aud constant 0; anodes cycle an0..an3 every 2^(REFRESH_BITS-2) cycles.
REQ-033 Send 0x1C, wait PLAY_SAMPLES strobes -> aud returns to constant 0, dp high; send 0x15 mid-play -> phase restarts, digits read 1,5.
REQ-034 With PS2_TIMEOUT_EN: send 5 bits, wait 1.1 ms, send full 0x1C -> 0x1C received correctly.

Source files
------------

// File: rtl/top_ps2_pcm.sv
// PS/2 keyboard to PCM tone player with a 4-digit hex display. Define PS2_TIMEOUT_EN to drop frames stalled for 1 ms.
// A byte reaches the decoder a few cycles after the stop-bit edge. There is no backpressure; a push into a full FIFO is dropped.
module top_ps2_pcm #(
  parameter int SYS_CLK_HZ   = 100_000_000,
  parameter int SAMPLE_HZ    = 32_000,
  parameter int PLAY_SAMPLES = 8000,
  parameter int REFRESH_BITS = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic aud,
  output logic a, b, c, d, e, f, g, dp,
  output logic an0, an1, an2, an3
);
  localparam logic [31:0] DIV_LAST  = 32'(SYS_CLK_HZ / SAMPLE_HZ - 1);
  localparam logic [31:0] PLAY_LAST = 32'(PLAY_SAMPLES - 1);

  function automatic logic [7:0] sine_rom(input logic [4:0] i);
    case (i)
      5'd0:  sine_rom = 8'h80; 5'd1:  sine_rom = 8'h99; 5'd2:  sine_rom = 8'hB1; 5'd3:  sine_rom = 8'hC7;
      5'd4:  sine_rom = 8'hDA; 5'd5:  sine_rom = 8'hEA; 5'd6:  sine_rom = 8'hF5; 5'd7:  sine_rom = 8'hFD;
      5'd8:  sine_rom = 8'hFF; 5'd9:  sine_rom = 8'hFD; 5'd10: sine_rom = 8'hF5; 5'd11: sine_rom = 8'hEA;
      5'd12: sine_rom = 8'hDA; 5'd13: sine_rom = 8'hC7; 5'd14: sine_rom = 8'hB1; 5'd15: sine_rom = 8'h99;
      5'd16: sine_rom = 8'h80; 5'd17: sine_rom = 8'h67; 5'd18: sine_rom = 8'h4F; 5'd19: sine_rom = 8'h39;
      5'd20: sine_rom = 8'h26; 5'd21: sine_rom = 8'h16; 5'd22: sine_rom = 8'h0B; 5'd23: sine_rom = 8'h03;
      5'd24: sine_rom = 8'h01; 5'd25: sine_rom = 8'h03; 5'd26: sine_rom = 8'h0B; 5'd27: sine_rom = 8'h16;
      5'd28: sine_rom = 8'h26; 5'd29: sine_rom = 8'h39; 5'd30: sine_rom = 8'h4F; default: sine_rom = 8'h67;
    endcase
  endfunction

  // Active-high segment pattern, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1111110; 4'h1: hex7 = 7'b0110000; 4'h2: hex7 = 7'b1101101; 4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011; 4'h5: hex7 = 7'b1011011; 4'h6: hex7 = 7'b1011111; 4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111; 4'h9: hex7 = 7'b1111011; 4'hA: hex7 = 7'b1110111; 4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110; 4'hD: hex7 = 7'b0111101; 4'hE: hex7 = 7'b1001111; default: hex7 = 7'b1000111;
    endcase
  endfunction

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_filt_q;
  logic [2:0] filt_cnt_q;
  logic       clk_diff, ps2_fall;

  assign clk_diff = clk_sync_q[1] != clk_filt_q;
  assign ps2_fall = clk_diff && (filt_cnt_q == 3'd7) && !clk_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      if (!clk_diff) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == 3'd7) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 3'd1;
      end
    end
  end

  // After ten edges frame_q holds {parity, d7..d0, start}; the stop bit is checked live.
  logic [3:0] bit_cnt_q;
  logic [9:0] frame_q;
  logic       frame_ok, push, to_clear;

  assign frame_ok = !frame_q[0] && dat_sync_q[1] && (^frame_q[9:1]);
  assign push     = ps2_fall && (bit_cnt_q == 4'd10) && frame_ok;

`ifdef PS2_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(SYS_CLK_HZ / 1000 - 1);
  logic [31:0] to_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || ps2_fall || bit_cnt_q == 4'd0) to_cnt_q <= '0;
    else                                      to_cnt_q <= to_cnt_q + 32'd1;
  end
  assign to_clear = (bit_cnt_q != 4'd0) && (to_cnt_q == TO_LAST);
`else
  assign to_clear = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      frame_q   <= '0;
    end else if (ps2_fall) begin
      frame_q   <= {dat_sync_q[1], frame_q[9:1]};
      bit_cnt_q <= (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (to_clear) begin
      bit_cnt_q <= '0;
    end
  end

  logic [7:0] fifo_mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] fifo_cnt_q;
  logic       do_push, pop;
  logic [7:0] pop_byte;

  assign do_push  = push && (fifo_cnt_q != 4'd8);
  assign pop      = fifo_cnt_q != 4'd0;
  assign pop_byte = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem_q[wr_ptr_q] <= frame_q[8:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 3'd1;
      fifo_cnt_q <= fifo_cnt_q + {3'b000, do_push} - {3'b000, pop};
    end
  end

  logic [31:0] div_q, samp_cnt_q;
  logic        strobe, brk_q, playing_q;
  logic [7:0]  last_code_q, key_count_q;
  logic [15:0] phase_q;

  assign strobe = div_q == DIV_LAST;

  always_ff @(posedge clk) begin
    if (rst || strobe) div_q <= '0;
    else               div_q <= div_q + 32'd1;
  end

  // A make code is applied after the strobe update so that it always restarts playback cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q       <= 1'b0;
      last_code_q <= '0;
      key_count_q <= '0;
      playing_q   <= 1'b0;
      samp_cnt_q  <= '0;
      phase_q     <= '0;
    end else begin
      if (playing_q && strobe) begin
        phase_q    <= phase_q + {2'b00, last_code_q, 6'b000000};
        samp_cnt_q <= samp_cnt_q + 32'd1;
        if (samp_cnt_q == PLAY_LAST) playing_q <= 1'b0;
      end
      if (pop) begin
        if (pop_byte == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (pop_byte == 8'hE0) begin
          brk_q <= brk_q;
        end else if (brk_q) begin
          brk_q <= 1'b0;
        end else begin
          last_code_q <= pop_byte;
          key_count_q <= key_count_q + 8'd1;
          playing_q   <= 1'b1;
          samp_cnt_q  <= '0;
          phase_q     <= '0;
        end
      end
    end
  end

  logic [8:0] acc_q;
  logic       aud_q;
  logic [7:0] sample;

  assign sample = sine_rom(phase_q[15:11]);

  always_ff @(posedge clk) begin
    if (rst || !playing_q) begin
      acc_q <= '0;
      aud_q <= 1'b0;
    end else begin
      acc_q <= {1'b0, acc_q[7:0]} + {1'b0, sample};
      aud_q <= acc_q[8];
    end
  end
  assign aud = aud_q;

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              sel;
  logic [3:0]              digit;

  always_ff @(posedge clk) begin
    if (rst) refresh_q <= '0;
    else     refresh_q <= refresh_q + REFRESH_BITS'(1);
  end

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = last_code_q[3:0];
    case (sel)
      2'd1:    digit = last_code_q[7:4];
      2'd2:    digit = key_count_q[3:0];
      2'd3:    digit = fifo_cnt_q;
      default: digit = last_code_q[3:0];
    endcase
  end

  assign {a, b, c, d, e, f, g}  = ~hex7(digit);
  assign {an3, an2, an1, an0}   = ~(4'b0001 << sel);
  assign dp                     = !((sel == 2'd0) && playing_q);
endmodule

// File: tb/tb_top_ps2_pcm.sv
// Directed + randomized bench for top_ps2_pcm with a keystroke-level reference model.
module tb_top_ps2_pcm;
  localparam int HALF     = 12;    // 6 us PS/2 clock period at 4 MHz
  localparam int PLAY_CYC = 4000;  // 200 samples x 20 cycles

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic aud, a, b, c, d, e, f, g, dp, an0, an1, an2, an3;
  int   n_assert = 0, n_fail = 0, cyc = 0;

  logic [7:0] m_last, m_kc;
  logic       m_brk;
  int         m_play_end;

  top_ps2_pcm #(.SYS_CLK_HZ(4_000_000), .SAMPLE_HZ(200_000), .PLAY_SAMPLES(200), .REFRESH_BITS(6)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .aud(aud),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] exp_seg(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'h7E; 4'h1: on = 7'h30; 4'h2: on = 7'h6D; 4'h3: on = 7'h79;
      4'h4: on = 7'h33; 4'h5: on = 7'h5B; 4'h6: on = 7'h5F; 4'h7: on = 7'h70;
      4'h8: on = 7'h7F; 4'h9: on = 7'h7B; 4'hA: on = 7'h77; 4'hB: on = 7'h1F;
      4'hC: on = 7'h4E; 4'hD: on = 7'h3D; 4'hE: on = 7'h4F; default: on = 7'h47;
    endcase
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Keystroke rules: F0 arms break, E0 ignored, next code after break is swallowed, others are makes.
  task automatic model_byte(input logic [7:0] bv);
    if (bv == 8'hF0) m_brk = 1'b1;
    else if (bv == 8'hE0) m_brk = m_brk;
    else if (m_brk) m_brk = 1'b0;
    else begin
      m_last = bv;
      m_kc = m_kc + 8'd1;
      m_play_end = cyc + PLAY_CYC;
    end
  endtask

  task automatic model_reset();
    m_last = 8'h00; m_kc = 8'h00; m_brk = 1'b0; m_play_end = 0;
  endtask

  task automatic ps2_bit(input logic v);
    @(posedge clk); #1 ps2_dat = v;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] dv, input logic bad_par, input logic bad_start, input logic bad_stop);
    logic par;
    par = (~^dv) ^ bad_par;
    ps2_bit(bad_start);
    for (int i = 0; i < 8; i++) ps2_bit(dv[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    #1 ps2_dat = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic read_digit(input int idx, output logic [6:0] seg, output logic dpv);
    logic [3:0] want, an;
    bit got;
    got = 0; seg = '0; dpv = 1'b0; an = '1;
    want = 4'b0001 << idx;
    want = ~want;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      an = {an3, an2, an1, an0};
      if (an == want) begin got = 1; seg = {a, b, c, d, e, f, g}; dpv = dp; end
    end
    if (!got) chk("digit_select_timeout", an, want);
  endtask

  task automatic check_display(input string tag, input logic exp_dp0);
    logic [6:0] seg;
    logic       dpv;
    logic [3:0] exp_dig [4];
    exp_dig[0] = m_last[3:0]; exp_dig[1] = m_last[7:4]; exp_dig[2] = m_kc[3:0]; exp_dig[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      read_digit(i, seg, dpv);
      chk($sformatf("%s_digit%0d", tag, i), seg, exp_seg(exp_dig[i]));
      if (i == 0) chk({tag, "_dp0"}, dpv, exp_dp0);
    end
  endtask

  task automatic watch_aud(input int n, output int ones, output int rises);
    logic prev;
    ones = 0; rises = 0; prev = aud;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (aud) ones++;
      if (aud && !prev) rises++;
      prev = aud;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk);
  endtask

  initial begin
    int ones, rises, bad_an;
    logic [3:0] want;
    logic [7:0] rb;

    model_reset();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then an idle scan: one anode per 16 cycles, no audio.
    bad_an = 0; ones = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rst_anodes", {an3, an2, an1, an0}, 4'b1110);
        chk("rst_segments", {a, b, c, d, e, f, g}, exp_seg(4'h0));
        chk("rst_dp", dp, 1'b1);
        chk("rst_aud", aud, 1'b0);
      end
      want = 4'b0001 << ((k >> 4) & 3);
      want = ~want;
      if ({an3, an2, an1, an0} != want) bad_an++;
      if (aud) ones++;
    end
    chk("scan_order_errors", bad_an, 0);
    chk("idle_aud_ones", ones, 0);

    // 0x1C make: tone, display, then silence after the tone length.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_byte(8'h1C);
    watch_aud(1500, ones, rises);
    chk("tone_rises_gt_100", rises > 100, 1'b1);
    chk("tone_density_mid", (ones > 450) && (ones < 1050), 1'b1);
    check_display("k1C", 1'b0);
    wait_until(m_play_end + 100);
    watch_aud(300, ones, rises);
    chk("tone_end_silent", ones, 0);
    check_display("k1C_end", 1'b1);

    // Restart mid-play with 0x15: tone must outlast the first one's end.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_byte(8'h1C);
    repeat (2500) @(posedge clk);
    send_frame(8'h15, 1'b0, 1'b0, 1'b0);
    model_byte(8'h15);
    wait_until(m_play_end - 1000);
    check_display("restart15", 1'b0);
    wait_until(m_play_end + 100);
    check_display("restart15_end", 1'b1);

    // Random make codes, sometimes preceded by an E0 prefix.
    for (int it = 0; it < 3; it++) begin
      do rb = 8'($urandom_range(0, 255)); while (rb == 8'hF0 || rb == 8'hE0);
      if ($urandom_range(0, 1) == 1) begin
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        model_byte(8'hE0);
      end
      send_frame(rb, 1'b0, 1'b0, 1'b0);
      model_byte(rb);
      check_display($sformatf("rand%0d", it), 1'b0);
    end
    wait_until(m_play_end + 100);

    // Corrupt frames: bad parity, bad start, bad stop. None may register.
    for (int v = 0; v < 3; v++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, v == 0, v == 1, v == 2);
    end
    check_display("bad_frames", 1'b1);
    watch_aud(300, ones, rises);
    chk("bad_frames_silent", ones, 0);

    // Break sequence swallows the following code; the next one plays.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    model_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_byte(8'h1C);
    check_display("break", 1'b1);
    watch_aud(300, ones, rises);
    chk("break_silent", ones, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_byte(8'h1C);
    check_display("after_break", 1'b0);

    // Reset during a partial frame and active playback.
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk("mid_reset_aud", aud, 1'b0);
    rst = 1'b0;
    model_reset();
    check_display("post_reset", 1'b1);
    do rb = 8'($urandom_range(0, 255)); while (rb == 8'hF0 || rb == 8'hE0);
    send_frame(rb, 1'b0, 1'b0, 1'b0);
    model_byte(rb);
    check_display("post_reset_rx", 1'b0);

`ifdef PS2_TIMEOUT_EN
    // Stalled partial frame is dropped after 1 ms (4000 cycles).
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (4400) @(posedge clk);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    model_byte(8'h1C);
    check_display("timeout_rx", 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
